// File: rtl/program_loader.sv
// Boot-time loader: receives a word-count-prefixed program image over UART 8N1
// and writes it into instruction memory, holding the CPU stalled until done.
`timescale 1ns/1ps
module program_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RX,
    output logic        WriteEnable,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        CPU_EN,
    output logic        Done,
    output logic        Error
);

    // state      | meaning
    // RX_IDLE    | line idle, waiting for a falling edge
    // RX_START   | confirming the start bit at mid-bit
    // RX_DATA    | sampling 8 data bits, LSB first
    // RX_STOP    | sampling the stop bit
    // LEN_LO     | waiting for word-count low byte
    // LEN_HI     | waiting for word-count high byte
    // BYTE0..3   | collecting the bytes of one instruction word
    // WRITE      | one-cycle instruction-memory write
    // DONE       | image loaded, CPU released (absorbing)
    // ERROR      | framing error or oversize image (absorbing)

    localparam int          CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    // Two cycles shorter than half a bit to absorb the synchronizer and edge-detect latency.
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        LEN_LO, LEN_HI, BYTE0, BYTE1, BYTE2, BYTE3, WRITE, DONE, ERROR
    } ld_state_t;

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          byte_valid, frame_err;
    logic          load_half, load_full, tick;

    ld_state_t     ld_state, ld_next;
    logic [7:0]    len_lo;
    logic [15:0]   len_word;
    logic [15:0]   words_left;
    logic [23:0]   word_buf;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign tick = (bit_cnt == '0);

    always_comb begin
        rx_next   = rx_state;
        load_half = 1'b0;
        load_full = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_next   = RX_START;
                    load_half = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (!rx_sync) begin
                        rx_next   = RX_DATA;
                        load_full = 1'b1;
                    end else begin
                        rx_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    load_full = 1'b1;
                    if (bit_idx == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (load_half)     bit_cnt <= HALF;
            else if (load_full) bit_cnt <= FULL;
            else if (!tick)     bit_cnt <= bit_cnt - CW'(1);
            if (rx_state == RX_START)              bit_idx <= '0;
            else if (rx_state == RX_DATA && tick)  bit_idx <= bit_idx + 3'd1;
            if (rx_state == RX_DATA && tick) shift <= {rx_sync, shift[7:1]};
            byte_valid <= (rx_state == RX_STOP) && tick && rx_sync;
            frame_err  <= (rx_state == RX_STOP) && tick && !rx_sync;
        end
    end

    assign len_word = {shift, len_lo};

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LEN_LO: if (byte_valid) ld_next = LEN_HI;
            LEN_HI: begin
                if (byte_valid) begin
                    if (len_word == 16'd0)               ld_next = DONE;
                    else if ({16'd0, len_word} > MAX_W)  ld_next = ERROR;
                    else                                 ld_next = BYTE0;
                end
            end
            BYTE0: if (byte_valid) ld_next = BYTE1;
            BYTE1: if (byte_valid) ld_next = BYTE2;
            BYTE2: if (byte_valid) ld_next = BYTE3;
            BYTE3: if (byte_valid) ld_next = WRITE;
            WRITE: ld_next = (words_left == 16'd1) ? DONE : BYTE0;
            DONE:  ld_next = DONE;
            ERROR: ld_next = ERROR;
            default: ld_next = ERROR;
        endcase
        if (frame_err && ld_state != DONE) ld_next = ERROR;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ld_state   <= LEN_LO;
            len_lo     <= '0;
            words_left <= '0;
            word_buf   <= '0;
            WriteData  <= '0;
            Address    <= BASE_ADDR;
        end else begin
            ld_state <= ld_next;
            if (byte_valid) begin
                case (ld_state)
                    LEN_LO: len_lo <= shift;
                    LEN_HI: words_left <= len_word;
                    BYTE0:  word_buf[7:0]   <= shift;
                    BYTE1:  word_buf[15:8]  <= shift;
                    BYTE2:  word_buf[23:16] <= shift;
                    BYTE3:  WriteData <= {shift, word_buf};
                    default: ;
                endcase
            end
            if (ld_state == WRITE) begin
                Address    <= Address + 32'd4;
                words_left <= words_left - 16'd1;
            end
        end
    end

    assign WriteEnable = (ld_state == WRITE);
    assign Done        = (ld_state == DONE);
    assign CPU_EN      = (ld_state == DONE);
    assign Error       = (ld_state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of complete images plus
// hand-written sequences for timing, glitch and mid-word reset corners.
`timescale 1ns/1ps
module tb_program_loader;
    localparam int          CPB  = 16;
    localparam int          MAXW = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          WIN  = CPB / 2 + 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        we;
    logic [31:0] addr, wdata;
    logic        cpu_en, done, error;

    program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .CLK(clk), .RESET(rst_n), .RX(rx),
        .WriteEnable(we), .Address(addr), .WriteData(wdata),
        .CPU_EN(cpu_en), .Done(done), .Error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cyc = -1, cpu_cyc = -1, err_cyc = -1;
    int          stop_cyc = 0;

    always @(negedge clk) begin
        if (we) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done && done_cyc < 0)   done_cyc = cyc;
        if (cpu_en && cpu_cyc < 0)  cpu_cyc = cyc;
        if (error && err_cyc < 0)   err_cyc = cyc;
    end

    int total = 0;
    int bad   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc = -1;
        cpu_cyc  = -1;
        err_cyc  = -1;
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(posedge clk);
        #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop_ok;
        stop_cyc = cyc;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    typedef struct {
        string       name;
        int          first;
        int          nbytes;
        int          bad_idx;
        int          nwr;
        logic [31:0] wa [4];
        logic [31:0] wd [4];
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] pool[$];

    initial begin
        // two-word image from the bring-up example
        vecs[0].name = "two_words"; vecs[0].first = pool.size();
        pool = {pool, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        vecs[0].nbytes = pool.size() - vecs[0].first; vecs[0].bad_idx = -1; vecs[0].nwr = 2;
        vecs[0].wa = '{32'h0, 32'h4, 32'h0, 32'h0};
        vecs[0].wd = '{32'h00A00513, 32'h00B00593, 32'h0, 32'h0};
        vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0;

        vecs[1].name = "empty"; vecs[1].first = pool.size();
        pool = {pool, 8'h00, 8'h00};
        vecs[1].nbytes = pool.size() - vecs[1].first; vecs[1].bad_idx = -1; vecs[1].nwr = 0;
        vecs[1].wa = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1].wd = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1].exp_done = 1'b1; vecs[1].exp_err = 1'b0;

        vecs[2].name = "frame_err"; vecs[2].first = pool.size();
        pool = {pool, 8'h01, 8'h00, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[2].nbytes = pool.size() - vecs[2].first; vecs[2].bad_idx = 2; vecs[2].nwr = 0;
        vecs[2].wa = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2].wd = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1;

        vecs[3].name = "oversize"; vecs[3].first = pool.size();
        pool = {pool, 8'h05, 8'h00};
        vecs[3].nbytes = pool.size() - vecs[3].first; vecs[3].bad_idx = -1; vecs[3].nwr = 0;
        vecs[3].wa = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3].wd = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3].exp_done = 1'b0; vecs[3].exp_err = 1'b1;

        vecs[4].name = "max_words"; vecs[4].first = pool.size();
        pool = {pool, 8'h04, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[4].nbytes = pool.size() - vecs[4].first; vecs[4].bad_idx = -1; vecs[4].nwr = 4;
        vecs[4].wa = '{32'h0, 32'h4, 32'h8, 32'hC};
        vecs[4].wd = '{32'h12345678, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF};
        vecs[4].exp_done = 1'b1; vecs[4].exp_err = 1'b0;

        vecs[5].name = "err_mid_word"; vecs[5].first = pool.size();
        pool = {pool, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        vecs[5].nbytes = pool.size() - vecs[5].first; vecs[5].bad_idx = 7; vecs[5].nwr = 1;
        vecs[5].wa = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5].wd = '{32'h00A00513, 32'h0, 32'h0, 32'h0};
        vecs[5].exp_done = 1'b0; vecs[5].exp_err = 1'b1;

        vecs[6].name = "done_absorbs"; vecs[6].first = pool.size();
        pool = {pool, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[6].nbytes = pool.size() - vecs[6].first; vecs[6].bad_idx = -1; vecs[6].nwr = 1;
        vecs[6].wa = '{32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6].wd = '{32'h12345678, 32'h0, 32'h0, 32'h0};
        vecs[6].exp_done = 1'b1; vecs[6].exp_err = 1'b0;

        // reset values
        do_reset();
        @(negedge clk);
        check32("rst_we",    {31'd0, we},     32'd0);
        check32("rst_addr",  addr,            BASE);
        check32("rst_wdata", wdata,           32'd0);
        check32("rst_cpu",   {31'd0, cpu_en}, 32'd0);
        check32("rst_done",  {31'd0, done},   32'd0);
        check32("rst_err",   {31'd0, error},  32'd0);

        for (int k = 0; k < 7; k++) begin
            do_reset();
            for (int j = 0; j < vecs[k].nbytes; j++)
                send_byte(pool[vecs[k].first + j], (j != vecs[k].bad_idx));
            repeat (20) @(posedge clk);
            @(negedge clk);
            check32({vecs[k].name, "_nwr"}, 32'(wr_addr_q.size()), 32'(vecs[k].nwr));
            for (int w = 0; w < vecs[k].nwr; w++) begin
                if (w < wr_addr_q.size()) begin
                    check32($sformatf("%s_addr%0d", vecs[k].name, w), wr_addr_q[w], vecs[k].wa[w]);
                    check32($sformatf("%s_data%0d", vecs[k].name, w), wr_data_q[w], vecs[k].wd[w]);
                end
            end
            check32({vecs[k].name, "_done"}, {31'd0, done},   {31'd0, vecs[k].exp_done});
            check32({vecs[k].name, "_cpu"},  {31'd0, cpu_en}, {31'd0, vecs[k].exp_done});
            check32({vecs[k].name, "_err"},  {31'd0, error},  {31'd0, vecs[k].exp_err});
        end

        // N = 0: Done/CPU_EN right after the second byte strobe
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check_win("empty_done_time", done_cyc, stop_cyc + 1, stop_cyc + WIN);
        check_win("empty_cpu_time",  cpu_cyc,  done_cyc, done_cyc);

        // one word: write timing and Done one cycle after the write
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(posedge clk);
        check32("one_nwr", 32'(wr_cyc_q.size()), 32'd1);
        if (wr_cyc_q.size() > 0) begin
            check_win("one_we_time",   wr_cyc_q[0], stop_cyc + 1, stop_cyc + WIN);
            check_win("one_done_time", done_cyc, wr_cyc_q[0] + 1, wr_cyc_q[0] + 1);
        end

        // oversize: Error right after the count high byte
        do_reset();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        check_win("over_err_time", err_cyc, stop_cyc + 1, stop_cyc + WIN);

        // short low glitch while idle must not produce a byte
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check32("glitch_nwr", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0)
            check32("glitch_data", wr_data_q[0], 32'h12345678);
        check32("glitch_done", {31'd0, done}, 32'd1);

        // reset in the middle of the second word, then a fresh image
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB * 3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check32("mid_rst_addr",  addr,           BASE);
        check32("mid_rst_wdata", wdata,          32'd0);
        check32("mid_rst_done",  {31'd0, done},  32'd0);
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check32("mid_rst_nwr", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check32("mid_rst_waddr", wr_addr_q[0], BASE);
            check32("mid_rst_wdat",  wr_data_q[0], 32'h44332211);
        end
        check32("mid_rst_done2", {31'd0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that receives a RISC-V program over a UART serial line and writes it word by word into the instruction memory. It is the write-side counterpart of the processor's instruction fetch path. It holds the processor stalled (program counter enable low) until the image is complete, then releases it. It sits between the board's UART RX pin and the instruction memory write port, alongside the datapath.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be ≥ 4
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written
- MAX_WORDS, 1024, largest accepted word count

- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  asynchronous, active-low reset
- RX  input  1  UART receive line, asynchronous to CLK, idle high, 8N1, LSB first
- WriteEnable  output  1  one-cycle instruction-memory write strobe
- Address  output  32  byte address for the current write, word aligned
- WriteData  output  32  instruction word for the current write
- CPU_EN  output  1  drives program counter EN; high only after a successful load
- Done  output  1  load finished successfully (sticky)
- Error  output  1  framing error or oversize image (sticky)

## Operation
- RX passes through a 2-flop synchronizer before use.
- UART receiver states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge.
  - START checks RX at CLKS_PER_BIT/2. Still low → DATA; high → IDLE (glitch, no byte).
  - DATA samples 8 bits, one every CLKS_PER_BIT, LSB first.
  - STOP samples at mid-bit. High → byte valid (1-cycle internal strobe); low → framing error.
- Image format:
  - 2-byte little-endian word count N.
  - Followed by 4·N bytes. Each word is little-endian: first byte → WriteData[7:0].
- Loader FSM states: LEN_LO, LEN_HI, BYTE0..BYTE3, WRITE, DONE, ERROR.
  - LEN_LO → LEN_HI on a byte.
  - LEN_HI:
    - N = 0 → DONE.
    - N > MAX_WORDS → ERROR.
    - Otherwise → BYTE0.
  - BYTEk → BYTEk+1 on a byte. BYTE3 → WRITE on a byte.
  - WRITE lasts one cycle with WriteEnable = 1. Then:
    - Address += 4.
    - Words-remaining decrements.
    - Next state is BYTE0, or DONE when 0 words remain.
  - A framing error in any non-DONE state → ERROR. The partial word is discarded.
  - DONE and ERROR are absorbing until reset. Later bytes are ignored; no further writes occur.
- CPU_EN = 1 only in DONE. Done = 1 only in DONE. Error = 1 only in ERROR.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment check is needed, since BASE_ADDR is required to be word aligned.

## Timing
- Reset values: WriteEnable 0, Address BASE_ADDR, WriteData 0, CPU_EN 0, Done 0, Error 0. Receiver in IDLE, loader in LEN_LO.
- Reset asserted mid-frame or mid-word:
  - Everything returns to the reset values immediately.
  - The partial byte or word is lost.
  - Words already written to instruction memory are not undone.
- Byte strobe fires within CLKS_PER_BIT/2 + 2 cycles of the stop-bit start edge on RX (synchronizer delay included).
- WriteEnable asserts the cycle after the 4th byte strobe of a word. Address and WriteData are valid and stable in that same cycle.
- Done and CPU_EN assert the cycle after the final WriteEnable, or the cycle after the LEN_HI byte when N = 0.
- The minimum gap between byte strobes (≈10·CLKS_PER_BIT) always exceeds the 1-cycle WRITE state. No byte is ever dropped.

## Test plan
- CLKS_PER_BIT=16, BASE_ADDR=0. Send 02 00 13 05 A0 00 93 05 B0 00 → two WriteEnable pulses:
  - Address 0x0, data 0x00A00513.
  - Address 0x4, data 0x00B00593.
  - Then Done=1, CPU_EN=1.
- Send 00 00 → no WriteEnable; Done and CPU_EN rise the cycle after the 2nd byte strobe.
- Send 01 00 then a byte with stop bit = 0 → Error=1, no WriteEnable, CPU_EN stays 0. Later valid bytes are ignored.
- MAX_WORDS=4. Send 05 00 → Error=1 the cycle after the 2nd byte strobe.
- A 3-cycle low glitch on RX while IDLE → no byte strobe, state unchanged.
- Assert RESET after 2 of 4 data bytes. Release and resend a full 1-word image → a single write to BASE_ADDR with the new word, then Done=1.
